// File: rtl/clock_core_sync.sv
// -----------------------------------------------------------------------------
// clock_core_sync
//
// Purpose:
//   Time-of-day counter (sec/min/hour) plus a completed-day counter, all in
//   the single clk domain. Fields advance by an enable cascade driven by a
//   one-cycle-per-second tick. Manual adjust pulses bump individual fields
//   without carrying. A combinational 12/24-hour display encoding is
//   derived from the internal 24-hour register.
//
// Optional feature macro:
//   CLOCK_CORE_ALARM_EN - adds alarm_hour/alarm_min/alarm_on inputs and an
//   alarm pulse output. The default build (macro undefined) omits them.
//
// Ports:
//   clk          in   system clock
//   clear        in   synchronous active-high reset, overrides every input
//   tick         in   one-cycle enable, one per second
//   adjust_sec   in   seconds +1, wraps, no carry
//   adjust_min   in   minutes +1, wraps, no carry
//   adjust_hour  in   hours +1, wraps, no carry
//   keep         in   hold: tick ignored while high (adjusts still honoured)
//   mode12       in   select 12-hour display encoding
//   sec/min/hour out  current time, hour is the internal 24h value
//   hour_disp    out  display hour (12h or 24h per mode12)
//   pm           out  high when mode12 active and hour >= 12
//   day_pulse    out  registered one-cycle pulse on full-day wrap
//   day_count    out  completed days, wraps modulo 2^DAY_W
//   alarm_hour   in   (CLOCK_CORE_ALARM_EN) alarm hour
//   alarm_min    in   (CLOCK_CORE_ALARM_EN) alarm minute
//   alarm_on     in   (CLOCK_CORE_ALARM_EN) alarm arm
//   alarm        out  (CLOCK_CORE_ALARM_EN) one-cycle pulse when a tick
//                     lands exactly on alarm_hour:alarm_min:00
//
// Per-cycle priority: clear > any adjust_* > tick. When any adjust is high
// the tick of that cycle is dropped on purpose (at most 1 s of time loss).
// -----------------------------------------------------------------------------
module clock_core_sync #(
  parameter int W        = 6,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23,
  parameter int DAY_W    = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             tick,
  input  logic             adjust_sec,
  input  logic             adjust_min,
  input  logic             adjust_hour,
  input  logic             keep,
  input  logic             mode12,
`ifdef CLOCK_CORE_ALARM_EN
  input  logic [W-1:0]     alarm_hour,
  input  logic [W-1:0]     alarm_min,
  input  logic             alarm_on,
  output logic             alarm,
`endif
  output logic [W-1:0]     sec,
  output logic [W-1:0]     min,
  output logic [W-1:0]     hour,
  output logic [W-1:0]     hour_disp,
  output logic             pm,
  output logic             day_pulse,
  output logic [DAY_W-1:0] day_count
);

  localparam logic [W-1:0] SEC_TOP  = W'(SEC_MAX);
  localparam logic [W-1:0] MIN_TOP  = W'(MIN_MAX);
  localparam logic [W-1:0] HOUR_TOP = W'(HOUR_MAX);
  localparam logic [W-1:0] TWELVE   = W'(12);
  // The 12-hour encoding only makes sense for a 0..23 hour field.
  localparam bit MODE12_LEGAL = (HOUR_MAX == 23);

  logic any_adjust;
  logic run;
  logic sec_at_top, min_at_top, hour_at_top;
  logic sec_inc, min_inc, hour_inc, day_inc;
  logic [W-1:0] sec_next, min_next, hour_next;

  assign any_adjust = adjust_sec | adjust_min | adjust_hour;
  // A tick only counts when nothing else claims the cycle.
  assign run = tick & ~keep & ~any_adjust;

  // Fields never exceed their MAX, so equality is a sufficient wrap test.
  assign sec_at_top  = (sec  == SEC_TOP);
  assign min_at_top  = (min  == MIN_TOP);
  assign hour_at_top = (hour == HOUR_TOP);

  // Adjust mode: each field follows its own pulse, no carry.
  // Tick mode: classic enable cascade.
  assign sec_inc  = any_adjust ? adjust_sec  : run;
  assign min_inc  = any_adjust ? adjust_min  : (run & sec_at_top);
  assign hour_inc = any_adjust ? adjust_hour : (run & sec_at_top & min_at_top);
  assign day_inc  = run & sec_at_top & min_at_top & hour_at_top;

  always_comb begin
    sec_next  = sec;
    min_next  = min;
    hour_next = hour;
    if (sec_inc)  sec_next  = sec_at_top  ? '0 : sec  + 1'b1;
    if (min_inc)  min_next  = min_at_top  ? '0 : min  + 1'b1;
    if (hour_inc) hour_next = hour_at_top ? '0 : hour + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      day_count <= '0;
      day_pulse <= 1'b0;
    end else begin
      sec       <= sec_next;
      min       <= min_next;
      hour      <= hour_next;
      day_pulse <= day_inc;
      if (day_inc) day_count <= day_count + 1'b1;
    end
  end

`ifdef CLOCK_CORE_ALARM_EN
  // Only a tick that rolls seconds over to 00 can land on hh:mm:00;
  // adjusts are excluded because run is low whenever an adjust is present.
  logic alarm_hit;
  assign alarm_hit = alarm_on & run & sec_at_top &
                     (min_next == alarm_min) & (hour_next == alarm_hour);

  always_ff @(posedge clk) begin
    if (clear) alarm <= 1'b0;
    else       alarm <= alarm_hit;
  end
`endif

  // Display encoding is combinational from the hour register.
  always_comb begin
    hour_disp = hour;
    pm        = 1'b0;
    if (mode12 && MODE12_LEGAL) begin
      pm = (hour >= TWELVE);
      if (hour == '0)          hour_disp = TWELVE;
      else if (hour > TWELVE)  hour_disp = hour - TWELVE;
    end
  end

endmodule

// File: tb/tb_clock_core_sync.sv
// -----------------------------------------------------------------------------
// tb_clock_core_sync
//
// Bench for clock_core_sync. A reference model keeps the time as plain
// integers and advances a tick as "seconds-of-day + 1" with division and
// modulo; adjusts bump one integer modulo its range. Directed table vectors,
// hand-written corner sequences and a randomized run all go through the same
// step() driver, which also compares the DUT against the model.
// -----------------------------------------------------------------------------
module tb_clock_core_sync;

  localparam int W        = 6;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int DAY_W    = 16;
  localparam int EW       = 3*W + 1 + DAY_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear, tick, adjust_sec, adjust_min, adjust_hour, keep, mode12;
  logic [W-1:0]     sec, min, hour, hour_disp;
  logic             pm, day_pulse;
  logic [DAY_W-1:0] day_count;
`ifdef CLOCK_CORE_ALARM_EN
  logic [W-1:0] alarm_hour, alarm_min;
  logic         alarm_on, alarm;
`endif

  clock_core_sync #(
    .W(W), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX), .HOUR_MAX(HOUR_MAX), .DAY_W(DAY_W)
  ) dut (
    .clk(clk), .clear(clear), .tick(tick),
    .adjust_sec(adjust_sec), .adjust_min(adjust_min), .adjust_hour(adjust_hour),
    .keep(keep), .mode12(mode12),
`ifdef CLOCK_CORE_ALARM_EN
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_on(alarm_on), .alarm(alarm),
`endif
    .sec(sec), .min(min), .hour(hour), .hour_disp(hour_disp), .pm(pm),
    .day_pulse(day_pulse), .day_count(day_count)
  );

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  int m_s = 0, m_m = 0, m_h = 0, m_day = 0;
  bit m_pulse = 0;
  bit m_alarm = 0;

  task automatic model_step(input bit clr, tk, as, am, ah, kp,
                            input int al_h, al_m, input bit al_on);
    int t;
    m_pulse = 0;
    m_alarm = 0;
    if (clr) begin
      m_s = 0; m_m = 0; m_h = 0; m_day = 0;
    end else if (as || am || ah) begin
      if (as) m_s = (m_s + 1) % (SEC_MAX + 1);
      if (am) m_m = (m_m + 1) % (MIN_MAX + 1);
      if (ah) m_h = (m_h + 1) % (HOUR_MAX + 1);
    end else if (tk && !kp) begin
      t = (m_h * (MIN_MAX + 1) + m_m) * (SEC_MAX + 1) + m_s + 1;
      if (t == (HOUR_MAX + 1) * (MIN_MAX + 1) * (SEC_MAX + 1)) begin
        t = 0;
        m_day = (m_day + 1) % (1 << DAY_W);
        m_pulse = 1;
      end
      m_s = t % (SEC_MAX + 1);
      m_m = (t / (SEC_MAX + 1)) % (MIN_MAX + 1);
      m_h = t / ((SEC_MAX + 1) * (MIN_MAX + 1));
      m_alarm = al_on && m_s == 0 && m_m == al_m && m_h == al_h;
    end
  endtask

  function automatic int model_disp(input int h, input bit m12);
    if (!m12 || HOUR_MAX != 23) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  function automatic void compare_state();
    logic [EW-1:0] e;
    logic [W-1:0] es, em, eh;
    logic ep;
    logic [DAY_W-1:0] ed;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    {es, em, eh, ep, ed} = e;
    chk("sec", sec, es);
    chk("min", min, em);
    chk("hour", hour, eh);
    chk("day_pulse", day_pulse, ep);
    chk("day_count", day_count, ed);
    chk("hour_disp", hour_disp, model_disp(int'(eh), mode12));
    chk("pm", pm, (mode12 && HOUR_MAX == 23 && eh >= 12) ? 1 : 0);
`ifdef CLOCK_CORE_ALARM_EN
    chk("alarm", alarm, m_alarm);
`endif
  endfunction

  // ---------------- driver ----------------
  // Called just after a posedge: drive, let the next edge sample, check #1 later.
  task automatic step(input bit clr, tk, as, am, ah, kp);
    int al_h = 0, al_m = 0;
    bit al_on = 0;
`ifdef CLOCK_CORE_ALARM_EN
    al_h = int'(alarm_hour); al_m = int'(alarm_min); al_on = alarm_on;
`endif
    clear = clr; tick = tk; adjust_sec = as; adjust_min = am;
    adjust_hour = ah; keep = kp;
    model_step(clr, tk, as, am, ah, kp, al_h, al_m, al_on);
    exp_q.push_back({W'(m_s), W'(m_m), W'(m_h), m_pulse, DAY_W'(m_day)});
    @(posedge clk);
    #1;
    compare_state();
  endtask

  // Walk to a target time with adjust pulses; day_count is left untouched.
  task automatic set_time(input int h, m, s);
    while (m_h != h || m_m != m || m_s != s)
      step(0, 0, m_s != s, m_m != m, m_h != h, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit clr, tk, as, am, ah, kp;
    int e_s, e_m, e_h;
    bit e_p;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int kept_s, kept_m, kept_h, pulses;
    clear = 1; tick = 0; adjust_sec = 0; adjust_min = 0; adjust_hour = 0;
    keep = 0; mode12 = 0;
`ifdef CLOCK_CORE_ALARM_EN
    alarm_hour = '0; alarm_min = '0; alarm_on = 1'b0;
`endif

    //                clr tk as am ah kp  s  m  h  p
    vecs[0] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 0};  // keep drops tick
    vecs[3] = '{0, 1, 1, 0, 0, 1,  2, 0, 0, 0};  // adjust honoured under keep
    vecs[4] = '{0, 1, 0, 1, 0, 0,  2, 1, 0, 0};  // tick lost to adjust
    vecs[5] = '{0, 0, 1, 1, 1, 0,  3, 2, 1, 0};  // all three at once
    vecs[6] = '{0, 1, 0, 0, 0, 0,  4, 2, 1, 0};
    vecs[7] = '{1, 1, 1, 1, 1, 0,  0, 0, 0, 0};  // clear wins
    vecs[8] = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 0};
    vecs[9] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0};  // idle holds

    // reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_sec", sec, 0);
    chk("reset_day_pulse", day_pulse, 0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].clr, vecs[i].tk, vecs[i].as, vecs[i].am, vecs[i].ah, vecs[i].kp);
      chk($sformatf("vec%0d_sec", i), sec, vecs[i].e_s);
      chk($sformatf("vec%0d_min", i), min, vecs[i].e_m);
      chk($sformatf("vec%0d_hour", i), hour, vecs[i].e_h);
      chk($sformatf("vec%0d_pulse", i), day_pulse, vecs[i].e_p);
    end

    // 1: sixty ticks roll one minute, no day pulse
    step(1, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("t1_sec", sec, i % 60);
      pulses += day_pulse;
    end
    chk("t1_min", min, 1);
    chk("t1_hour", hour, 0);
    chk("t1_no_pulse", pulses, 0);

    // 2: 23:59:59 + tick -> day wrap
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0, 0);
    chk("t2_no_pulse_on_adjust", day_pulse, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("t2_sec", sec, 0);
    chk("t2_min", min, 0);
    chk("t2_hour", hour, 0);
    chk("t2_pulse", day_pulse, 1);
    chk("t2_day", day_count, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_pulse_drop", day_pulse, 0);

    // 3: keep holds the state, adjust still works
    set_time(3, 7, 9);
    kept_s = m_s; kept_m = m_m; kept_h = m_h;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 1);
    chk("t3_keep_sec", sec, kept_s);
    chk("t3_keep_min", min, kept_m);
    chk("t3_keep_hour", hour, kept_h);
    step(0, 1, 1, 0, 0, 1);
    chk("t3_adj_keep", sec, kept_s + 1);

    // 4: adjust at MAX has no carry; tick+adjust drops tick
    set_time(0, 5, 59);
    step(0, 0, 1, 0, 0, 0);
    chk("t4_sec_wrap", sec, 0);
    chk("t4_no_carry", min, 5);
    set_time(0, 10, 30);
    step(0, 1, 0, 1, 0, 0);
    chk("t4_min", min, 11);
    chk("t4_sec", sec, 30);

    // 5: display encoding
    begin
      int hrs[5]  = '{0, 11, 12, 13, 23};
      int disp[5] = '{12, 11, 12, 1, 11};
      int pms[5]  = '{0, 0, 1, 1, 1};
      for (int i = 0; i < 5; i++) begin
        set_time(hrs[i], 0, 0);
        mode12 = 1; #1;
        chk($sformatf("t5_disp_h%0d", hrs[i]), hour_disp, disp[i]);
        chk($sformatf("t5_pm_h%0d", hrs[i]), pm, pms[i]);
        if (hrs[i] == 13) begin
          mode12 = 0; #1;
          chk("t5_disp24_h13", hour_disp, 13);
          chk("t5_pm24_h13", pm, 0);
        end
        mode12 = 0;
      end
    end

    // 6: clear wins over a tick, including the day counter
    set_time(12, 34, 56);
    chk("t6_day_before", day_count, 1);
    step(1, 1, 0, 0, 0, 0);
    chk("t6_sec", sec, 0);
    chk("t6_hour", hour, 0);
    chk("t6_day", day_count, 0);

`ifdef CLOCK_CORE_ALARM_EN
    alarm_hour = W'(0); alarm_min = W'(1); alarm_on = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      step(0, 1, 0, 0, 0, 0);
      pulses += alarm;
      if (i == 60) chk("t6_alarm_60th", alarm, 1);
    end
    chk("t6_alarm_once", pulses, 1);
`endif

    // randomized run against the model, starting near a day boundary
    set_time(23, 58, 0);
    for (int i = 0; i < 1500; i++) begin
      mode12 = $urandom_range(0, 1);
`ifdef CLOCK_CORE_ALARM_EN
      alarm_on = $urandom_range(0, 1);
      alarm_hour = W'($urandom_range(0, 1) ? 0 : 23);
      alarm_min = W'($urandom_range(0, 59));
`endif
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_core_sync.md
Name: clock_core_sync

Overview:
Parametrised, fully synchronous successor of the sec/min/hour time counter.
- All three fields (sec/min/hour) advance in a single clk domain via enable cascade, replacing the ripple-clocked per-field counters.
- Adds a day counter with a wrap pulse, a 12/24-hour display mode, and defined adjust/tick collision rules.
- Sits between the 1 Hz tick generator and the display/BCD path.

Parameters:
W, 6, width of sec/min/hour registers
SEC_MAX, 59, terminal value of seconds field
MIN_MAX, 59, terminal value of minutes field
HOUR_MAX, 23, terminal value of hours field; 12h display mode only legal when 23
DAY_W, 16, width of day counter

Ports:
clk  in  1  system clock
clear  in  1  synchronous active-high reset
tick  in  1  one-cycle enable, one per second
adjust_sec  in  1  one-cycle pulse: seconds +1, no carry
adjust_min  in  1  one-cycle pulse: minutes +1, no carry
adjust_hour  in  1  one-cycle pulse: hours +1, no carry
keep  in  1  hold: tick ignored while high
mode12  in  1  select 12-hour display encoding
sec  out  W  seconds, 0..SEC_MAX
min  out  W  minutes, 0..MIN_MAX
hour  out  W  hours, internal 24h value, 0..HOUR_MAX
hour_disp  out  W  display hour (12h or 24h per mode12)
pm  out  1  high when hour>=12 and mode12 active
day_pulse  out  1  one-cycle pulse on full-day wrap
day_count  out  DAY_W  completed days, wraps at 2^DAY_W-1 -> 0

Behaviour:
- Reset and clock: clock is clk; reset is synchronous, active-high, named clear.
- clear: sec/min/hour/day_count <= 0, day_pulse <= 0. clear overrides every other input in the same cycle.
- Priority per cycle: clear > any adjust_* > tick.
- Adjust:
  - Each asserted adjust_* increments its own field; field wraps MAX -> 0.
  - No carry into the next field; day_pulse is never asserted and day_count is never changed by an adjust.
  - Multiple adjust_* in one cycle: each asserted field increments independently.
  - If any adjust_* is high, tick is dropped that cycle (time loss <=1 s is accepted).
  - Adjusts are honoured regardless of keep.
- Tick counting (tick=1, keep=0, no adjust):
  - sec <= sec+1. At SEC_MAX: sec <= 0 and min increments.
  - At MIN_MAX with sec carry: min <= 0 and hour increments.
  - At HOUR_MAX with min carry: hour <= 0, day_count +1, day_pulse <= 1 for exactly one cycle.
- keep=1: tick ignored; state holds.
- Latency: fields update on the clk edge that samples tick, so new values are visible 1 cycle after tick. day_pulse is registered and coincides with the first cycle showing 00:00:00.
- Out-of-range field values (> MAX) cannot be reached. Each increment compares with ==MAX, so no >= check is needed.
- Display outputs: hour_disp and pm are combinational from the hour register (no extra latency).
  - mode12=0: hour_disp = hour, pm = 0.
  - mode12=1 and HOUR_MAX==23: hour 0 -> 12; 1..12 -> same value; 13..23 -> hour-12; pm = (hour>=12).
  - HOUR_MAX!=23: mode12 is ignored; behaves as mode12=0.
- tick held high for N cycles counts N seconds; no edge detection is performed.

Optional Feature:
CLOCK_CORE_ALARM_EN
- Defined:
  - Adds inputs alarm_hour[W], alarm_min[W] and alarm_on[1], plus output alarm[1].
  - alarm is a registered one-cycle pulse when a tick (not an adjust) moves state to alarm_hour:alarm_min:00 while alarm_on=1.
  - clear forces alarm to 0.
- Undefined: these ports and the compare logic are absent; the rest of the behaviour is identical.

Test Plan:
1. clear, then 60 ticks with keep=0 -> sec 0..59 then 0, min=1, hour=0, day_pulse never high.
2. From clear, pulse adjust_hour x23, adjust_min x59, adjust_sec x59, then one tick -> 00:00:00, day_pulse high exactly one cycle, day_count=1.
3. keep=1, 10 ticks -> state unchanged. adjust_sec during keep -> sec increments by 1.
4. State 00:05:59, adjust_sec -> 00:05:00 (no carry). State 00:10:30, tick and adjust_min in the same cycle -> 00:11:30.
5. mode12=1 with hour = 0, 11, 12, 13, 23 -> hour_disp = 12, 11, 12, 1, 11 and pm = 0, 0, 1, 1, 1. With mode12=0 and hour=13 -> hour_disp=13, pm=0.
6. clear asserted in the same cycle as tick at 12:34:56 -> next cycle 00:00:00, day_count=0. With CLOCK_CORE_ALARM_EN: alarm 00:01, alarm_on=1, from clear issue 60 ticks -> alarm pulses once on the 60th tick.
